// File: rtl/addsub_pkg.sv
// Shared constants and types for the digit-serial add/subtract controller.
package addsub_pkg;

   localparam int unsigned NIBW = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_slice4.sv
// Combinational 4-bit ripple adder built from full-adder cells.
module addsub_slice4
   import addsub_pkg::*;
(
   input  logic [NIBW-1:0] x,
   input  logic [NIBW-1:0] y,
   input  logic            cin,
   output logic [NIBW-1:0] s,
   output logic            cout,
   output logic            c3
);

   logic [NIBW:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < NIBW; i++) begin : g_fa
      assign s[i]   = x[i] ^ y[i] ^ c[i];
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
   end

   assign cout = c[NIBW];
   // Carry into the top bit, needed for signed overflow.
   assign c3   = c[NIBW-1];

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial add/subtract controller: one nibble per clock, LS nibble first.
module addsub_seq
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned NIB  = WIDTH / NIBW;
   localparam int unsigned IdxW = $clog2(NIB);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

   state_t           state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             cy_q, cy_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [NIBW-1:0]  sl_s;
   logic             sl_cout;
   logic             sl_c3;

   addsub_slice4 u_slice (
      .x    (a_q[NIBW-1:0]),
      .y    (b_q[NIBW-1:0] ^ {NIBW{op_q}}),
      .cin  (cy_q),
      .s    (sl_s),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cy_d     = cy_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            ready   = 1'b1;
            done    = (state_q == ST_DONE);
            state_d = ST_IDLE;
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = b;
               op_d    = op;
               idx_d   = '0;
               acc_d   = '0;
               // Subtract is a + ~b + 1: preload the carry with the op bit.
               cy_d    = (op == OP_SUB);
            end
         end
         ST_RUN: begin
            busy  = 1'b1;
            a_d   = a_q >> NIBW;
            b_d   = b_q >> NIBW;
            acc_d = {sl_s, acc_q[WIDTH-1:NIBW]};
            cy_d  = sl_cout;
            idx_d = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
               state_d  = ST_DONE;
               idx_d    = '0;
               result_d = {sl_s, acc_q[WIDTH-1:NIBW]};
               carry_d  = sl_cout;
               ovf_d    = sl_cout ^ sl_c3;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cy_q     <= 1'b0;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cy_q     <= cy_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
      end
   end

   assign result   = result_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WIDTH=16): vector table, corner sequences, random ops.
module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [15:0] a;
   logic [15:0] b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry;
   logic        overflow;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs[8];

   addsub_seq #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .carry    (carry),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Called at a negedge; returns edges from accept to done and busy cycles seen.
   task automatic run_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int busy_cyc);
      chk("ready_before_accept", {31'd0, ready}, 32'd1);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = ~x;
      b     = ~y;
      op    = ~o;
      lat      = 0;
      busy_cyc = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cyc++;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
   endtask

   function automatic logic [17:0] model(input logic o, input logic [15:0] x,
                                         input logic [15:0] y);
      logic [16:0] full;
      logic [15:0] r;
      logic        v;
      logic [15:0] ny;
      ny   = ~y;
      full = o ? ({1'b0, x} + {1'b0, ny} + 17'd1) : ({1'b0, x} + {1'b0, y});
      r    = full[15:0];
      if (o) v = (x[15] != y[15]) && (r[15] != x[15]);
      else   v = (x[15] == y[15]) && (r[15] != x[15]);
      return {full[16], v, r};
   endfunction

   initial begin
      int          lat;
      int          bc;
      int          n;
      int          dcount;
      logic [17:0] m;
      logic        ro;
      logic [15:0] rx;
      logic [15:0] ry;

      vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      vecs[7] = '{1'b1, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1};

      rst   = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      chk("rst_carry", {31'd0, carry}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);

      // Start held through reset must not be accepted until after release.
      start = 1'b1;
      a     = 16'h0001;
      b     = 16'h0002;
      @(posedge clk);
      @(negedge clk);
      chk("start_in_reset", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      #1;
      chk("no_accept_before_edge", {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("accept_after_release", {31'd0, busy}, 32'd1);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("release_result", {16'd0, result}, 32'h0003);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         chk($sformatf("vec%0d_result", i), {16'd0, result}, {16'd0, vecs[i].r});
         chk($sformatf("vec%0d_carry", i), {31'd0, carry}, {31'd0, vecs[i].c});
         chk($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].v});
         chk($sformatf("vec%0d_latency", i), lat, 4);
         chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      end

      // Start held during RUN with shifting inputs, then back-to-back accept in DONE.
      start = 1'b1;
      op    = 1'b0;
      a     = 16'h1111;
      b     = 16'h2222;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("run_busy", {30'd0, busy, done}, 32'd2);
         a  = 16'($urandom);
         b  = 16'($urandom);
         op = i[0];
         @(posedge clk);
         @(negedge clk);
      end
      chk("first_done", {31'd0, done}, 32'd1);
      chk("ignored_start_result", {16'd0, result}, 32'h3333);
      chk("ignored_start_carry", {31'd0, carry}, 32'd0);
      chk("ignored_start_ovf", {31'd0, overflow}, 32'd0);
      op = 1'b1;
      a  = 16'h0100;
      b  = 16'h0001;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accepted", {31'd0, busy}, 32'd1);
      n = 1;
      while (!done && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("b2b_done_spacing", n, 5);
      chk("b2b_result", {16'd0, result}, 32'h00FF);
      chk("b2b_carry", {31'd0, carry}, 32'd1);
      chk("b2b_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);

      // Reset during the second RUN cycle aborts and clears everything.
      start = 1'b1;
      op    = 1'b0;
      a     = 16'h4444;
      b     = 16'h1111;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      chk("abort_carry", {31'd0, carry}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      dcount = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_idle_ready", {31'd0, ready}, 32'd1);

      for (int i = 0; i < 1000; i++) begin
         ro = 1'($urandom_range(0, 1));
         rx = 16'($urandom);
         ry = 16'($urandom);
         m  = model(ro, rx, ry);
         run_op(ro, rx, ry, lat, bc);
         chk($sformatf("rnd%0d_result", i), {16'd0, result}, {16'd0, m[15:0]});
         chk($sformatf("rnd%0d_carry", i), {31'd0, carry}, {31'd0, m[17]});
         chk($sformatf("rnd%0d_ovf", i), {31'd0, overflow}, {31'd0, m[16]});
         chk($sformatf("rnd%0d_latency", i), lat, 4);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle, digit-serial add/subtract controller for WIDTH-bit operands. It feeds one 4-bit add/sub slice one nibble per clock, least-significant nibble first, with the carry chained through a register. It presents a start/ready/done handshake to the surrounding datapath. Signed two's-complement and unsigned results are both supported through separate carry and overflow flags.

## Interface
- WIDTH, 16: operand/result width. Must be a multiple of 4 and ≥ 8. NIB = WIDTH/4.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request. Accepted on a rising edge when start=1 and ready=1.
- op  in  1  0 = add (a+b), 1 = subtract (a−b). Sampled only at accept.
- a  in  WIDTH  operand A, sampled only at accept
- b  in  WIDTH  operand B, sampled only at accept
- ready  out  1  controller can accept start
- busy  out  1  a computation is in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  last completed result, held until the next completion
- carry  out  1  carry out of the MSB. For subtract this is no-borrow: 1 when a ≥ b unsigned.
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1.
- Transitions:
  - IDLE→RUN on accept.
  - RUN→DONE after NIB nibble steps.
  - DONE→RUN on accept (back-to-back allowed).
  - DONE→IDLE otherwise.
- Accept:
  - Latch a, b and op.
  - Nibble index idx ← 0.
  - Carry register ← op, so subtract computes a + ~b + 1.
- Each RUN edge:
  - Slice input nibbles are a[4idx+3:4idx] and b[4idx+3:4idx] XOR {4{op}}, plus the carry register.
  - Sum nibble shifts into the internal accumulator.
  - Carry register ← slice carry out; idx increments.
  - On the last step (idx = NIB−1), also capture the slice's internal carry into bit 3 for the overflow computation.
- Publish: on the edge RUN→DONE, update result, carry and overflow together. They never show partial values.
- start while busy=1 is ignored and has no side effect. a, b and op changes during RUN have no effect.
- Arithmetic is modulo 2^WIDTH, with no saturation.

## Timing
- Reset (async, immediate): state=IDLE, ready=1, busy=0, done=0, result=0, carry=0, overflow=0, idx=0, internal registers=0.
- Accept at edge k:
  - busy=1 from k until edge k+NIB.
  - done=1 for exactly the cycle between edges k+NIB and k+NIB+1.
  - result, carry and overflow are valid from edge k+NIB.
- Latency start→done is NIB cycles. Back-to-back throughput is one op per NIB+1 cycles.
- Start asserted in DONE: done still pulses for the completing op, and the new op enters RUN on that edge.
- Reset mid-RUN aborts the op with no done pulse. Outputs return to their reset values.
- Reset released with start=1: nothing is accepted until the first rising edge after deassertion.

## Structure
- Shared package addsub_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE
  - op constants OP_ADD=0, OP_SUB=1
  - nibble width constant NIBW=4
- One sub-module, addsub_slice4: combinational 4-bit add with inputs x, y, cin and outputs s, cout, c3 (carry into bit 3).
  - The controller does the B inversion itself.
  - Built from full-adder cells.
- Controller contains:
  - FSM
  - idx counter, width clog2(NIB)
  - carry register
  - operand shift registers
  - result accumulator

## Test plan (WIDTH=16, NIB=4)
- Add 0x1234+0x0FFF → result 0x2233, carry 0, overflow 0. done exactly 4 cycles after accept, busy high for 4 cycles.
- Sub 0x0005−0x0007 → result 0xFFFE, carry 0, overflow 0. Sub 0x0007−0x0005 → result 0x0002, carry 1, overflow 0.
- Boundary values:
  - 0x7FFF+0x0001 → 0x8000, overflow 1, carry 0.
  - 0xFFFF+0x0001 → 0x0000, carry 1, overflow 0.
  - 0x8000−0x0001 → 0x7FFF, overflow 1, carry 1.
- Start held during RUN with changing a/b/op → ignored, first op's result unchanged. Start in the DONE cycle → second op accepted, its done lands 5 cycles after the first done.
- Assert rst on the 2nd RUN cycle → outputs go to reset values immediately (ready=1), no done pulse, previous result cleared to 0.
- Randomised 1000 ops with both op values against a reference model → result, carry and overflow match, and the done-to-accept protocol holds.
